// File: rtl/hazard3_ahb_pkg.sv
// Shared AHB-lite encodings and PMP gate error-FSM state encodings.
package hazard3_ahb_pkg;

  localparam int unsigned HTRANS_W    = 2;
  localparam int unsigned FLT_COUNT_W = 8;

  localparam logic [HTRANS_W-1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [HTRANS_W-1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    GATE_IDLE = 2'b00,
    GATE_ERR1 = 2'b01,
    GATE_ERR2 = 2'b10
  } gate_state_t;

  // Saturating increment of the fault counter.
  function automatic logic [FLT_COUNT_W-1:0] flt_count_inc(input logic [FLT_COUNT_W-1:0] c);
    return (&c) ? c : c + FLT_COUNT_W'(1);
  endfunction

endpackage

// File: rtl/hazard3_pmp_gate_faultlog.sv
// Records the address/direction of the most recent PMP-killed access and a saturating kill count.
module hazard3_pmp_gate_faultlog
  import hazard3_ahb_pkg::*;
#(
  parameter int unsigned W_ADDR = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   kill,
  input  logic [W_ADDR-1:0]      kill_addr,
  input  logic                   kill_write,
  input  logic                   clr,
  output logic [W_ADDR-1:0]      flt_addr,
  output logic                   flt_write,
  output logic [FLT_COUNT_W-1:0] flt_count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt_addr  <= '0;
      flt_write <= 1'b0;
      flt_count <= '0;
    end else if (kill) begin
      flt_addr  <= kill_addr;
      flt_write <= kill_write;
      // A clear coinciding with a kill still counts that kill.
      flt_count <= clr ? FLT_COUNT_W'(1) : flt_count_inc(flt_count);
    end else if (clr) begin
      flt_count <= '0;
    end
  end

endmodule

// File: rtl/hazard3_pmp_ahb_gate.sv
// AHB-lite gate between core and bus: PMP-killed address phases are dropped and answered with a
// two-cycle error response. Optional fault log enabled by HAZARD3_PMP_GATE_FAULT_LOG_EN.
module hazard3_pmp_ahb_gate
  import hazard3_ahb_pkg::*;
#(
  parameter int unsigned W_ADDR = 32,
  parameter int unsigned W_DATA = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W_ADDR-1:0] s_haddr,
  input  logic [1:0]        s_htrans,
  input  logic              s_hwrite,
  input  logic [2:0]        s_hsize,
  input  logic [3:0]        s_hprot,
  input  logic [W_DATA-1:0] s_hwdata,
  output logic              s_hready,
  output logic              s_hresp,
  output logic [W_DATA-1:0] s_hrdata,
  output logic [W_ADDR-1:0] m_haddr,
  output logic [1:0]        m_htrans,
  output logic              m_hwrite,
  output logic [2:0]        m_hsize,
  output logic [3:0]        m_hprot,
  output logic [W_DATA-1:0] m_hwdata,
  input  logic              m_hready,
  input  logic              m_hresp,
  input  logic [W_DATA-1:0] m_hrdata,
  output logic [W_ADDR-1:0] pmp_addr,
  output logic              pmp_m_mode,
  output logic              pmp_write,
  input  logic              pmp_kill,
  output logic [W_ADDR-1:0] flt_addr,
  output logic              flt_write,
  output logic [7:0]        flt_count,
  input  logic              flt_clr
);

  gate_state_t state;
  logic        dph_pass;
  logic        accept_c;
  logic        kill_c;

  assign pmp_addr   = s_haddr;
  assign pmp_write  = s_hwrite;
  assign pmp_m_mode = s_hprot[1];

  assign accept_c = s_htrans[1] && s_hready;
  assign kill_c   = accept_c && pmp_kill;

  assign m_haddr  = s_haddr;
  assign m_hwrite = s_hwrite;
  assign m_hsize  = s_hsize;
  assign m_hprot  = s_hprot;
  assign m_hwdata = s_hwdata;

  // Error FSM plus a flag marking an in-flight forwarded data phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= GATE_IDLE;
      dph_pass <= 1'b0;
    end else begin
      case (state)
        GATE_IDLE: state <= kill_c ? GATE_ERR1 : GATE_IDLE;
        GATE_ERR1: state <= GATE_ERR2;
        GATE_ERR2: state <= kill_c ? GATE_ERR1 : GATE_IDLE;
        default:   state <= GATE_IDLE;
      endcase
      if (s_hready) dph_pass <= accept_c && !pmp_kill;
    end
  end

  // Core-side response: downstream pass-through, or the two-cycle error.
  always_comb begin
    s_hready = m_hready;
    s_hresp  = m_hresp;
    s_hrdata = m_hrdata;
    case (state)
      GATE_ERR1: begin
        s_hready = 1'b0;
        s_hresp  = 1'b1;
        s_hrdata = '0;
      end
      GATE_ERR2: begin
        s_hready = 1'b1;
        s_hresp  = 1'b1;
        s_hrdata = '0;
      end
      default: ;
    endcase
    if (!rst_n) s_hresp = 1'b0;
  end

  // Stalled cycles stay IDLE downstream unless a forwarded transfer is waiting on its data phase.
  always_comb begin
    m_htrans = s_htrans;
    if (!rst_n) begin
      m_htrans = HTRANS_IDLE;
    end else if (s_hready) begin
      if (kill_c) m_htrans = HTRANS_IDLE;
    end else if (!dph_pass) begin
      m_htrans = HTRANS_IDLE;
    end
  end

`ifdef HAZARD3_PMP_GATE_FAULT_LOG_EN
  hazard3_pmp_gate_faultlog #(
    .W_ADDR (W_ADDR)
  ) u_faultlog (
    .clk        (clk),
    .rst_n      (rst_n),
    .kill       (kill_c),
    .kill_addr  (s_haddr),
    .kill_write (s_hwrite),
    .clr        (flt_clr),
    .flt_addr   (flt_addr),
    .flt_write  (flt_write),
    .flt_count  (flt_count)
  );
`else
  logic flt_clr_unused;
  assign flt_clr_unused = flt_clr;
  assign flt_addr       = '0;
  assign flt_write      = 1'b0;
  assign flt_count      = '0;
`endif

endmodule

// File: tb/tb_hazard3_pmp_ahb_gate.sv
// Scoreboard bench for hazard3_pmp_ahb_gate: driver pushes expectations, negedge monitor checks them.
module tb_hazard3_pmp_ahb_gate;
  import hazard3_ahb_pkg::*;

`ifdef HAZARD3_PMP_GATE_FAULT_LOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif
  localparam logic [31:0] MAGIC = 32'h5A5A_5A5A;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_haddr = '0;
  logic [1:0]  s_htrans = 2'b00;
  logic        s_hwrite = 1'b0;
  logic [2:0]  s_hsize = 3'b010;
  logic [3:0]  s_hprot = 4'b0011;
  logic [31:0] s_hwdata = '0;
  logic        s_hready, s_hresp;
  logic [31:0] s_hrdata;
  logic [31:0] m_haddr, m_hwdata, m_hrdata;
  logic [1:0]  m_htrans;
  logic        m_hwrite, m_hready, m_hresp;
  logic [2:0]  m_hsize;
  logic [3:0]  m_hprot;
  logic [31:0] pmp_addr;
  logic        pmp_m_mode, pmp_write;
  logic        pmp_kill = 1'b0;
  logic [31:0] flt_addr;
  logic        flt_write;
  logic [7:0]  flt_count;
  logic        flt_clr = 1'b0;

  always #5 clk = ~clk;

  hazard3_pmp_ahb_gate #(.W_ADDR(32), .W_DATA(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite), .s_hsize(s_hsize),
    .s_hprot(s_hprot), .s_hwdata(s_hwdata), .s_hready(s_hready), .s_hresp(s_hresp),
    .s_hrdata(s_hrdata),
    .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hwrite(m_hwrite), .m_hsize(m_hsize),
    .m_hprot(m_hprot), .m_hwdata(m_hwdata), .m_hready(m_hready), .m_hresp(m_hresp),
    .m_hrdata(m_hrdata),
    .pmp_addr(pmp_addr), .pmp_m_mode(pmp_m_mode), .pmp_write(pmp_write), .pmp_kill(pmp_kill),
    .flt_addr(flt_addr), .flt_write(flt_write), .flt_count(flt_count), .flt_clr(flt_clr)
  );

  // Downstream slave: returns addr^MAGIC after slv_waits wait states.
  int unsigned slv_waits = 0;
  logic        sl_dp;
  logic [31:0] sl_addr;
  int unsigned sl_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sl_dp <= 1'b0; sl_addr <= '0; sl_cnt <= 0;
    end else if (m_hready) begin
      if (m_htrans[1]) begin
        sl_dp <= 1'b1; sl_addr <= m_haddr; sl_cnt <= slv_waits;
      end else begin
        sl_dp <= 1'b0;
      end
    end else begin
      sl_cnt <= sl_cnt - 1;
    end
  end
  assign m_hready = !(sl_dp && sl_cnt != 0);
  assign m_hresp  = 1'b0;
  assign m_hrdata = sl_dp ? (sl_addr ^ MAGIC) : 32'h0;

  typedef struct packed {
    logic [1:0]  htrans;
    logic [31:0] addr;
    logic        write;
    logic [3:0]  prot;
  } exp_a_t;

  typedef struct packed {
    logic        err;
    logic        resp;
    logic [31:0] rdata;
    logic [7:0]  waits;
  } exp_d_t;

  exp_a_t aq[$];
  exp_d_t dq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: address-phase and data-phase checks at the negedge.
  logic dp_active = 1'b0;
  int   wcnt = 0;
  always @(negedge clk) begin
    exp_a_t ea;
    exp_d_t ed;
    if (!rst_n) begin
      aq.delete(); dq.delete(); dp_active = 1'b0; wcnt = 0;
    end else begin
      if (dp_active) begin
        if (dq.size() == 0) begin
          checks++; errors++;
          $display("FAIL dq_empty actual=data_phase expected=none t=%0t", $time);
          dp_active = 1'b0;
        end else if (!s_hready) begin
          wcnt++;
          if (dq[0].err) begin
            chk("err1_hresp", 32'(s_hresp), 32'd1);
            chk("err1_mtrans", 32'(m_htrans), 32'(HTRANS_IDLE));
            chk("err1_rdata", s_hrdata, 32'h0);
          end else begin
            chk("wait_hresp", 32'(s_hresp), 32'd0);
            chk("wait_mtrans_hold", 32'(m_htrans), 32'(s_htrans));
          end
        end else begin
          ed = dq.pop_front();
          chk("dp_waits", 32'(wcnt), 32'(ed.waits));
          chk("dp_hresp", 32'(s_hresp), 32'(ed.resp));
          chk("dp_rdata", s_hrdata, ed.rdata);
          wcnt = 0;
        end
      end
      if (s_htrans[1] && s_hready) begin
        if (aq.size() == 0) begin
          checks++; errors++;
          $display("FAIL aq_empty actual=accept expected=none t=%0t", $time);
        end else begin
          ea = aq.pop_front();
          chk("ap_mtrans", 32'(m_htrans), 32'(ea.htrans));
          chk("ap_hwdata", m_hwdata, s_hwdata);
          if (ea.htrans == HTRANS_NONSEQ) begin
            chk("ap_haddr", m_haddr, ea.addr);
            chk("ap_hwrite", 32'(m_hwrite), 32'(ea.write));
            chk("ap_hprot", 32'(m_hprot), 32'(ea.prot));
          end
        end
        dp_active = 1'b1;
      end else if (s_hready) begin
        dp_active = 1'b0;
      end
    end
  end

  task automatic idle(input int n);
    s_htrans = HTRANS_IDLE;
    pmp_kill = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present one transfer; returns #1 after the edge that accepted it.
  task automatic xfer(input logic [31:0] a, input logic w, input logic m, input logic k,
                      input logic [31:0] rd);
    exp_a_t ea;
    exp_d_t ed;
    bit acc;
    ea.htrans = k ? HTRANS_IDLE : HTRANS_NONSEQ;
    ea.addr   = a;
    ea.write  = w;
    ea.prot   = m ? 4'b0011 : 4'b0001;
    ed.err    = k;
    ed.resp   = k;
    ed.rdata  = k ? 32'h0 : rd;
    ed.waits  = k ? 8'd1 : 8'(slv_waits);
    aq.push_back(ea);
    dq.push_back(ed);
    s_haddr = a; s_hwrite = w; s_hprot = ea.prot; s_htrans = HTRANS_NONSEQ;
    s_hwdata = ~a; pmp_kill = k;
    #1;
    chk("pmp_addr", pmp_addr, a);
    chk("pmp_write", 32'(pmp_write), 32'(w));
    chk("pmp_m_mode", 32'(pmp_m_mode), 32'(m));
    acc = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_hready) begin acc = 1'b1; break; end
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=stalled expected=accept addr=%h", a);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: a permitted NONSEQ is presented but must not reach the bus.
    s_htrans = HTRANS_NONSEQ; s_haddr = 32'h2000_0000;
    #2;
    chk("rst_mtrans", 32'(m_htrans), 32'(HTRANS_IDLE));
    chk("rst_hresp", 32'(s_hresp), 32'd0);
    chk("rst_hready", 32'(s_hready), 32'd1);
    chk("rst_flt_count", 32'(flt_count), 32'd0);
    chk("rst_flt_addr", flt_addr, 32'h0);
    chk("rst_flt_write", 32'(flt_write), 32'd0);
    s_htrans = HTRANS_IDLE;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // Permitted M-mode read, zero wait; then one with downstream waits while a kill is queued.
    xfer(32'h2000_0000, 1'b0, 1'b1, 1'b0, 32'h7A5A_5A5A);
    slv_waits = 2;
    xfer(32'h2000_0100, 1'b0, 1'b1, 1'b0, 32'h7A5A_5B5A);
    slv_waits = 0;
    // Killed U-mode write.
    xfer(32'h4000_0010, 1'b1, 1'b0, 1'b1, 32'h0);
    idle(2);
    chk("flt_addr_a", flt_addr, LOG ? 32'h4000_0010 : 32'h0);
    chk("flt_write_a", 32'(flt_write), LOG ? 32'd1 : 32'd0);
    chk("flt_count_a", 32'(flt_count), LOG ? 32'd1 : 32'd0);

    // Kill, then a permitted access accepted in ERR2.
    xfer(32'h4000_0020, 1'b0, 1'b0, 1'b1, 32'h0);
    xfer(32'h2000_0040, 1'b0, 1'b1, 1'b0, 32'h7A5A_5A1A);
    idle(2);
    chk("flt_addr_b", flt_addr, LOG ? 32'h4000_0020 : 32'h0);
    chk("flt_write_b", 32'(flt_write), 32'd0);
    chk("flt_count_b", 32'(flt_count), LOG ? 32'd2 : 32'd0);

    // Clear alone, then back-to-back kills.
    flt_clr = 1'b1; idle(1); flt_clr = 1'b0;
    chk("flt_count_clr", 32'(flt_count), 32'd0);
    xfer(32'h4000_0100, 1'b1, 1'b0, 1'b1, 32'h0);
    xfer(32'h4000_0104, 1'b0, 1'b0, 1'b1, 32'h0);
    idle(3);
    chk("flt_count_b2b", 32'(flt_count), LOG ? 32'd2 : 32'd0);
    chk("flt_addr_b2b", flt_addr, LOG ? 32'h4000_0104 : 32'h0);

    // Saturation, then clear coincident with a kill.
    for (int i = 0; i < 300; i++)
      xfer(32'h4000_1000 + 32'(i * 4), 1'(i), 1'b0, 1'b1, 32'h0);
    idle(3);
    chk("flt_count_sat", 32'(flt_count), LOG ? 32'd255 : 32'd0);
    flt_clr = 1'b1;
    xfer(32'h4000_2000, 1'b1, 1'b0, 1'b1, 32'h0);
    flt_clr = 1'b0;
    idle(3);
    chk("flt_count_clrkill", 32'(flt_count), LOG ? 32'd1 : 32'd0);
    chk("flt_addr_clrkill", flt_addr, LOG ? 32'h4000_2000 : 32'h0);
    chk("flt_write_clrkill", 32'(flt_write), LOG ? 32'd1 : 32'd0);

    // Reset pulsed during ERR1.
    xfer(32'h4000_3000, 1'b0, 1'b0, 1'b1, 32'h0);
    chk("err1_pre_hready", 32'(s_hready), 32'd0);
    chk("err1_pre_hresp", 32'(s_hresp), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_err_hresp", 32'(s_hresp), 32'd0);
    chk("rst_err_hready", 32'(s_hready), 32'd1);
    chk("rst_err_mtrans", 32'(m_htrans), 32'(HTRANS_IDLE));
    chk("rst_err_flt_count", 32'(flt_count), 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    s_htrans = HTRANS_IDLE; pmp_kill = 1'b0;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_hresp", 32'(s_hresp), 32'd0);
      chk("post_rst_hready", 32'(s_hready), 32'd1);
    end
    @(posedge clk); #1;
    xfer(32'h2000_0080, 1'b1, 1'b1, 1'b0, 32'h7A5A_5ADA);
    idle(4);
    chk("drain_dq", 32'(dq.size()), 32'd0);
    chk("drain_aq", 32'(aq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard3_pmp_ahb_gate.md
HAZARD3_PMP_AHB_GATE -- requirements
Module: hazard3_pmp_ahb_gate

Interface
REQ-001 SHALL have parameter W_ADDR, default 32: address width.
REQ-002 SHALL have parameter W_DATA, default 32: data width.
REQ-003 SHALL have clk (in, 1): clock. rst_n (in, 1): reset, asynchronous, active-low.
REQ-004 SHALL have core-side AHB-lite slave port:
- s_haddr in W_ADDR
- s_htrans in 2
- s_hwrite in 1
- s_hsize in 3
- s_hprot in 4; bit 1 set means M-mode
- s_hwdata in W_DATA
- s_hready out 1
- s_hresp out 1
- s_hrdata out W_DATA
REQ-005 SHALL have bus-side AHB-lite master port:
- m_haddr, m_htrans, m_hwrite, m_hsize, m_hprot, m_hwdata: out, widths as REQ-004
- m_hready, m_hresp, m_hrdata: in, widths as REQ-004
REQ-006 SHALL have PMP query port:
- pmp_addr out W_ADDR
- pmp_m_mode out 1
- pmp_write out 1
- pmp_kill in 1: combinational answer in the same cycle
REQ-007 SHALL have fault log port:
- flt_addr out W_ADDR
- flt_write out 1
- flt_count out 8
- flt_clr in 1

Function
REQ-008 SHALL drive pmp_addr=s_haddr, pmp_write=s_hwrite and pmp_m_mode=s_hprot[1] combinationally in every cycle.
REQ-009 SHALL define an address-phase accept as s_htrans[1] && s_hready.
REQ-010 SHALL, on an accept with pmp_kill=0, pass s_haddr, s_htrans, s_hwrite, s_hsize and s_hprot unchanged to the m_* outputs.
REQ-011 SHALL, on an accept with pmp_kill=1:
- force m_htrans=2'b00 (IDLE) in that cycle
- enter state ERR1 on the next edge
REQ-012 SHALL force m_htrans=IDLE in any cycle where s_hready=0, except during a pass-through data phase, where the request fields SHALL pass through unchanged.
REQ-013 SHALL implement the FSM IDLE -> ERR1 -> ERR2 -> IDLE:
- ERR1 always advances to ERR2
- ERR2 advances to IDLE, or to ERR1 if a new killed accept occurs in ERR2
REQ-014 SHALL, in IDLE, drive s_hready=m_hready, s_hresp=m_hresp and s_hrdata=m_hrdata.
REQ-015 SHALL, in ERR1, drive s_hready=0 and s_hresp=1; in ERR2, drive s_hready=1 and s_hresp=1; s_hrdata SHALL be 0 in both states.
REQ-016 SHALL treat an accept occurring in ERR2 exactly as in IDLE: pass-through or kill per REQ-010/011.
REQ-017 SHALL drive m_hwdata=s_hwdata at all times; the downstream sees no transfer for killed accesses.
REQ-018 SHALL perform no buffering: zero added latency for permitted transfers; a killed transfer completes exactly 2 cycles after its address phase.

Reset
REQ-019 SHALL, with rst_n low, force state IDLE, m_htrans=IDLE, s_hresp=0, s_hready=m_hready, flt_addr=0, flt_write=0 and flt_count=0.
REQ-020 SHALL, when reset asserts in ERR1 or ERR2, abandon the error response with no further s_hresp=1 after deassertion.

Configuration
REQ-021 SHALL, with HAZARD3_PMP_GATE_FAULT_LOG_EN defined, capture s_haddr and s_hwrite into flt_addr/flt_write on each killed accept.
REQ-022 SHALL, with HAZARD3_PMP_GATE_FAULT_LOG_EN defined, increment flt_count on each killed accept, saturating at 255.
REQ-023 SHALL, on flt_clr, zero flt_count; if flt_clr coincides with a kill, flt_count SHALL become 1 and the address SHALL be captured.
REQ-024 SHALL, without HAZARD3_PMP_GATE_FAULT_LOG_EN, tie flt_addr, flt_write and flt_count to 0 with no flops.

Structure
REQ-025 SHALL take HTRANS encodings and ERR FSM state encodings from the shared hazard3_ahb_pkg header.
REQ-026 SHALL place the fault log in sub-module hazard3_pmp_gate_faultlog, instantiated only under the macro.

Verification
REQ-027 SHALL cover: M-mode read 0x2000_0000 with pmp_kill=0 -> m_htrans=NONSEQ, s_hrdata=m_hrdata, 0 added cycles.
REQ-028 SHALL cover: U-mode write 0x4000_0010 with pmp_kill=1 -> m_htrans=IDLE; next cycle hready=0/hresp=1; then hready=1/hresp=1; flt_addr=0x4000_0010, flt_write=1.
REQ-029 SHALL cover: a killed access, then a permitted access presented in ERR2 -> forwarded in the ERR2 cycle; its data phase completes normally.
REQ-030 SHALL cover: back-to-back killed accesses -> ERR1, ERR2, ERR1, ERR2; flt_count=2.
REQ-031 SHALL cover: 300 killed accesses, then flt_clr coincident with a kill -> flt_count holds 255, then becomes 1.
REQ-032 SHALL cover: rst_n pulsed low during ERR1 -> s_hresp=0 immediately; the gate is IDLE after release.
